// File: rtl/weight_mem_pkg.sv
// Shared types and lane placement for the weight SRAM scheduler.
// Writer 1 owns lanes [63:48]/[31:16], writer 2 owns [47:32]/[15:0].
package weight_mem_pkg;

    localparam int ROW_BITS  = 11;
    localparam int ADDR_BITS = 12;

    typedef enum logic {CLEAR, RUN} state_e;

    localparam logic [63:0] BM_W1_HI = 64'hFFFF_0000_0000_0000;
    localparam logic [63:0] BM_W1_LO = 64'h0000_0000_FFFF_0000;
    localparam logic [63:0] BM_W2_HI = 64'h0000_FFFF_0000_0000;
    localparam logic [63:0] BM_W2_LO = 64'h0000_0000_0000_FFFF;

    typedef struct packed {
        logic [63:0] bm;
        logic [63:0] din;
    } lane_t;

    // port2: 0 = writer 1, 1 = writer 2; hi = halfword address bit 11
    function automatic lane_t place_lane(input logic port2, input logic hi, input logic [15:0] data);
        lane_t l;
        case ({port2, hi})
            2'b00:   l.bm = BM_W1_LO;
            2'b01:   l.bm = BM_W1_HI;
            2'b10:   l.bm = BM_W2_LO;
            default: l.bm = BM_W2_HI;
        endcase
        l.din = {4{data}} & l.bm;
        return l;
    endfunction

endpackage

// File: rtl/weight_mem_sched_if.sv
// Request/response and macro-pin bundle for weight_mem_sched.
// slave = scheduler side, master = loaders, neuron core and SRAM macro side.
interface weight_mem_sched_if;
    import weight_mem_pkg::*;

    logic                 wr1_valid;
    logic                 wr1_ready;
    logic [ADDR_BITS-1:0] wr1_addr;
    logic [15:0]          wr1_data;
    logic                 wr2_valid;
    logic                 wr2_ready;
    logic [ADDR_BITS-1:0] wr2_addr;
    logic [15:0]          wr2_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rd_data_valid;
    logic [31:0]          rd_data;
    logic                 init_done;
    logic                 mem_men;
    logic                 mem_wen;
    logic                 mem_ren;
    logic [ROW_BITS-1:0]  mem_addr;
    logic [63:0]          mem_din;
    logic [63:0]          mem_bm;
    logic [63:0]          mem_dout;

    modport slave (
        input  wr1_valid, wr1_addr, wr1_data,
        input  wr2_valid, wr2_addr, wr2_data,
        input  rd_valid, rd_addr, mem_dout,
        output wr1_ready, wr2_ready, rd_ready, rd_data_valid, rd_data, init_done,
        output mem_men, mem_wen, mem_ren, mem_addr, mem_din, mem_bm
    );

    modport master (
        output wr1_valid, wr1_addr, wr1_data,
        output wr2_valid, wr2_addr, wr2_data,
        output rd_valid, rd_addr, mem_dout,
        input  wr1_ready, wr2_ready, rd_ready, rd_data_valid, rd_data, init_done,
        input  mem_men, mem_wen, mem_ren, mem_addr, mem_din, mem_bm
    );

endinterface

// File: rtl/weight_mem_rd_pipe.sv
// Two-stage read tracker: remembers which 32-bit half was asked for, then
// registers that half of the macro output so rd_data lands two cycles after accept.
module weight_mem_rd_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        accept_i,
    input  logic        half_i,
    input  logic [63:0] mem_dout_i,
    output logic        rd_data_valid_o,
    output logic [31:0] rd_data_o
);
    logic        v1_q;
    logic        v2_q;
    logic        half_q;
    logic [31:0] data_q;
    logic [1:0][31:0] halves;

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        assign halves[gi] = mem_dout_i[gi*32 +: 32];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            half_q <= 1'b0;
            data_q <= '0;
        end else begin
            v1_q <= accept_i;
            v2_q <= v1_q;
            if (accept_i) half_q <= half_i;
            if (v1_q)     data_q <= halves[half_q];
        end
    end

    assign rd_data_valid_o = v2_q;
    assign rd_data_o       = data_q;

endmodule

// File: rtl/weight_mem_sched.sv
// Shares one single-port 2048x64 weight SRAM between two halfword writers and one reader.
// Define WMEM_WR_MERGE_EN to fold same-row writes from both loaders into one macro write.
module weight_mem_sched
    import weight_mem_pkg::*;
#(
    parameter int DEPTH          = 2048,
    parameter int ROW_W          = 11,
    parameter int STARVE_MAX     = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    weight_mem_sched_if.slave  bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             rr_q, rr_d;
    logic             init_done_q, init_done_d;

    logic [1:0]                 wv;
    logic [1:0][ADDR_BITS-1:0]  waddr;
    logic [1:0][15:0]           wdata;
    lane_t                      lane [2];

    logic [1:0]       gnt_w;
    logic             gnt_rd;
    logic             wen;
    logic             ren;
    logic [ROW_W-1:0] addr;
    logic [63:0]      bm;
    logic [63:0]      din;
    logic             any_w;
    logic             force_w;
    logic             same_row;

    assign wv    = {bus.wr2_valid, bus.wr1_valid};
    assign waddr = {bus.wr2_addr, bus.wr1_addr};
    assign wdata = {bus.wr2_data, bus.wr1_data};

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign lane[gi] = place_lane(1'(gi), waddr[gi][ROW_BITS], wdata[gi]);
    end

    assign any_w    = |wv;
    assign force_w  = any_w && (starve_q == SW'(STARVE_MAX));
    assign same_row = (waddr[0][ROW_W-1:0] == waddr[1][ROW_W-1:0]);

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        starve_d    = starve_q;
        rr_d        = rr_q;
        init_done_d = init_done_q;
        gnt_w       = 2'b00;
        gnt_rd      = 1'b0;
        wen         = 1'b0;
        ren         = 1'b0;
        addr        = '0;
        bm          = '0;
        din         = '0;

        case (state_q)
            CLEAR: begin
                wen   = 1'b1;
                addr  = row_q;
                bm    = '1;
                row_d = row_q + ROW_W'(1);
                if (row_q == ROW_W'(DEPTH - 1)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                if (bus.rd_valid && !force_w) begin
                    gnt_rd   = 1'b1;
                    ren      = 1'b1;
                    addr     = bus.rd_addr[ROW_W-1:0];
                    starve_d = !any_w ? '0
                             : (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
                end else if (any_w) begin
                    gnt_w = (&wv) ? (rr_q ? 2'b10 : 2'b01) : wv;
`ifdef WMEM_WR_MERGE_EN
                    if ((&wv) && same_row) gnt_w = 2'b11;
`endif
                    wen  = 1'b1;
                    addr = gnt_w[0] ? waddr[0][ROW_W-1:0] : waddr[1][ROW_W-1:0];
                    if (gnt_w[0]) begin
                        bm  = bm  | lane[0].bm;
                        din = din | lane[0].din;
                    end
                    if (gnt_w[1]) begin
                        bm  = bm  | lane[1].bm;
                        din = din | lane[1].din;
                    end
                    starve_d = '0;
                    // A merged write serves both loaders, so neither is owed the next turn
                    if (gnt_w != 2'b11) rr_d = gnt_w[0];
                end else begin
                    starve_d = '0;
                end
            end
        endcase

        // Nothing reaches the macro or the clients while reset is held
        if (!rst_n) begin
            gnt_w  = 2'b00;
            gnt_rd = 1'b0;
            wen    = 1'b0;
            ren    = 1'b0;
            addr   = '0;
            bm     = '0;
            din    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CLEAR_ON_RESET ? CLEAR : RUN;
            row_q       <= '0;
            starve_q    <= '0;
            rr_q        <= 1'b0;
            init_done_q <= !CLEAR_ON_RESET;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            starve_q    <= starve_d;
            rr_q        <= rr_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.wr1_ready = gnt_w[0];
    assign bus.wr2_ready = gnt_w[1];
    assign bus.rd_ready  = gnt_rd;
    assign bus.init_done = init_done_q;
    assign bus.mem_men   = wen | ren;
    assign bus.mem_wen   = wen;
    assign bus.mem_ren   = ren;
    assign bus.mem_addr  = addr;
    assign bus.mem_bm    = bm;
    assign bus.mem_din   = din;

    weight_mem_rd_pipe u_rd_pipe (
        .clk             (clk),
        .rst_n           (rst_n),
        .accept_i        (gnt_rd),
        .half_i          (bus.rd_addr[ROW_BITS]),
        .mem_dout_i      (bus.mem_dout),
        .rd_data_valid_o (bus.rd_data_valid),
        .rd_data_o       (bus.rd_data)
    );

endmodule

// File: tb/tb_weight_mem_sched.sv
// Bench for weight_mem_sched: behavioural SRAM macro plus a reference model of
// grants, lane placement and read data; directed steps then random traffic.
module tb_weight_mem_sched;
    localparam int DEPTH  = 2048;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    weight_mem_sched_if bus();

    weight_mem_sched #(
        .DEPTH          (DEPTH),
        .ROW_W          (11),
        .STARVE_MAX     (STARVE),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // SRAM macro: masked write, read data valid the cycle after mem_ren
    logic [63:0] sram [DEPTH];
    logic [63:0] dout_q;
    always @(posedge clk) begin
        if (bus.mem_men && bus.mem_wen)
            sram[bus.mem_addr] <= (sram[bus.mem_addr] & ~bus.mem_bm) | (bus.mem_din & bus.mem_bm);
        if (bus.mem_men && bus.mem_ren)
            dout_q <= sram[bus.mem_addr];
    end
    assign bus.mem_dout = dout_q;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t     rdq [$];
    logic [63:0] ref_mem [DEPTH];
    int          m_starve;
    bit          m_rr;      // 0: wr1 wins a tie, 1: wr2 wins a tie
    int          cyc;
    int          n_cmp;
    int          n_bad;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_in(input logic v1, input logic [11:0] a1, input logic [15:0] d1,
                          input logic v2, input logic [11:0] a2, input logic [15:0] d2,
                          input logic rv, input logic [11:0] ra);
        bus.wr1_valid = v1; bus.wr1_addr = a1; bus.wr1_data = d1;
        bus.wr2_valid = v2; bus.wr2_addr = a2; bus.wr2_data = d2;
        bus.rd_valid  = rv; bus.rd_addr  = ra;
    endtask

    function automatic int lane_shift(input int port, input logic hi);
        if (port == 1) return hi ? 48 : 16;
        return hi ? 32 : 0;
    endfunction

    // Predict and check one RUN cycle from the current inputs, then advance the model
    task automatic eval_cycle(input string tag);
        logic v1, v2, rv, g_rd, g_w, e1, e2, merged, exp_v;
        logic [11:0]  a1, a2, ra;
        logic [63:0]  ebm, edin, row_val;
        logic [10:0]  eaddr, wrow;
        logic [159:0] obs, exp;
        #2;
        v1 = bus.wr1_valid; v2 = bus.wr2_valid; rv = bus.rd_valid;
        a1 = bus.wr1_addr;  a2 = bus.wr2_addr;  ra = bus.rd_addr;
        g_rd   = rv && !((v1 || v2) && m_starve == STARVE);
        g_w    = (v1 || v2) && !g_rd;
        merged = 1'b0;
        e1 = 1'b0; e2 = 1'b0;
        if (g_w) begin
            if (v1 && v2) begin
`ifdef WMEM_WR_MERGE_EN
                merged = (a1[10:0] == a2[10:0]);
`endif
                if (merged)     begin e1 = 1'b1; e2 = 1'b1; end
                else if (!m_rr) e1 = 1'b1;
                else            e2 = 1'b1;
            end else begin
                e1 = v1; e2 = v2;
            end
        end
        ebm = '0; edin = '0;
        if (e1) begin
            ebm  = ebm  | (64'hFFFF << lane_shift(1, a1[11]));
            edin = edin | (64'(bus.wr1_data) << lane_shift(1, a1[11]));
        end
        if (e2) begin
            ebm  = ebm  | (64'hFFFF << lane_shift(2, a2[11]));
            edin = edin | (64'(bus.wr2_data) << lane_shift(2, a2[11]));
        end
        eaddr = g_rd ? ra[10:0] : e1 ? a1[10:0] : e2 ? a2[10:0] : 11'd0;
        exp = {14'b0, 1'b1, e1, e2, g_rd, g_rd || g_w, g_w, g_rd, eaddr, ebm, edin};
        obs = {14'b0, bus.init_done, bus.wr1_ready, bus.wr2_ready, bus.rd_ready,
               bus.mem_men, bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_bm, bus.mem_din};
        chk(tag, obs, exp);

        exp_v = (rdq.size() > 0) && (rdq[0].due == cyc);
        chk({tag, "_rdv"}, 160'(bus.rd_data_valid), 160'(exp_v));
        if (exp_v) begin
            chk({tag, "_rdata"}, 160'(bus.rd_data), 160'(rdq[0].data));
            void'(rdq.pop_front());
        end

        if (g_w) begin
            wrow = e1 ? a1[10:0] : a2[10:0];
            ref_mem[wrow] = (ref_mem[wrow] & ~ebm) | edin;
            m_starve = 0;
            if (!merged) m_rr = e1;
        end else if (g_rd) begin
            m_starve = (v1 || v2) ? ((m_starve < STARVE) ? m_starve + 1 : STARVE) : 0;
            row_val = ref_mem[ra[10:0]];
            rdq.push_back('{cyc + 2, ra[11] ? row_val[63:32] : row_val[31:0]});
        end else begin
            m_starve = 0;
        end
    endtask

    bit starve_pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        for (int i = 0; i < DEPTH; i++) sram[i] = {$urandom, $urandom};
        dout_q = '0;

        // Reset held with every request pending
        rst_n = 1'b0;
        set_in(1'b1, 12'h001, 16'h1111, 1'b1, 12'h002, 16'h2222, 1'b1, 12'h003);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #2;
            chk("rst_quiet", 160'({bus.wr1_ready, bus.wr2_ready, bus.rd_ready, bus.mem_men,
                                   bus.mem_wen, bus.mem_ren, bus.rd_data_valid}), 160'(0));
        end
        next_cycle();
        rst_n = 1'b1;

        // Clear sweep: one row per cycle, requests ignored
        for (int i = 0; i < DEPTH; i++) begin
            #2;
            chk("sweep", {14'b0, bus.init_done, bus.wr1_ready, bus.wr2_ready, bus.rd_ready,
                          bus.mem_men, bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_bm, bus.mem_din},
                         {14'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 11'(i), {64{1'b1}}, 64'h0});
            if (i == 0)
                chk("reset_rd_out", 160'({bus.rd_data_valid, bus.rd_data}), 160'(0));
            next_cycle();
        end

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        m_starve = 0; m_rr = 1'b0; rdq.delete(); cyc = 0;

        set_in(1'b0, 12'h0, 16'h0, 1'b0, 12'h0, 16'h0, 1'b0, 12'h0);
        eval_cycle("init_done_run");
        next_cycle();

        // Both writers continuously valid: strict alternation starting at wr1
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 12'h00A, 16'($urandom), 1'b1, 12'h814, 16'($urandom), 1'b0, 12'h0);
            eval_cycle("rr");
            chk("rr_order", 160'(bus.wr1_ready), 160'(i % 2 == 0));
            next_cycle();
        end

        // Directed write then read of halfword 0x805
        set_in(1'b1, 12'h805, 16'hABCD, 1'b0, 12'h0, 16'h0, 1'b0, 12'h0);
        eval_cycle("wr805");
        chk("wr805_bm", 160'(bus.mem_bm), 160'(64'hFFFF_0000_0000_0000));
        chk("wr805_row", 160'(bus.mem_addr), 160'(11'd5));
        next_cycle();
        set_in(1'b0, 12'h0, 16'h0, 1'b0, 12'h0, 16'h0, 1'b1, 12'h805);
        eval_cycle("rd805");
        next_cycle();
        set_in(1'b0, 12'h0, 16'h0, 1'b0, 12'h0, 16'h0, 1'b0, 12'h0);
        eval_cycle("rd805_wait");
        next_cycle();
        eval_cycle("rd805_out");
        chk("rd805_data", 160'({bus.rd_data_valid, bus.rd_data}), 160'({1'b1, 32'hABCD_0000}));
        next_cycle();

        // Read held against a pending wr1: four reads, one forced write, repeat
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, {1'($urandom), 11'($urandom_range(0, 7))}, 16'($urandom),
                   1'b0, 12'h0, 16'h0,
                   1'b1, {1'($urandom), 11'($urandom_range(0, 7))});
            eval_cycle("starve");
            chk("starve_seq", 160'(bus.rd_ready), 160'(starve_pat[i]));
            next_cycle();
        end

`ifdef WMEM_WR_MERGE_EN
        set_in(1'b1, 12'h003, 16'h1234, 1'b1, 12'h003, 16'h5678, 1'b0, 12'h0);
        eval_cycle("merge");
        chk("merge_pins", 160'({bus.wr1_ready, bus.wr2_ready, bus.mem_bm, bus.mem_din}),
                          160'({2'b11, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_1234_5678}));
        next_cycle();
`endif

        // Random traffic over a handful of rows so reads hit written data
        for (int i = 0; i < 600; i++) begin
            set_in(1'($urandom_range(0, 1)), {1'($urandom), 11'($urandom_range(0, 7))}, 16'($urandom),
                   1'($urandom_range(0, 1)), {1'($urandom), 11'($urandom_range(0, 7))}, 16'($urandom),
                   1'($urandom_range(0, 9) < 6), {1'($urandom), 11'($urandom_range(0, 7))});
            eval_cycle("rand");
            next_cycle();
        end
        set_in(1'b0, 12'h0, 16'h0, 1'b0, 12'h0, 16'h0, 1'b0, 12'h0);
        for (int i = 0; i < 3; i++) begin
            eval_cycle("drain");
            next_cycle();
        end

        // Reset pulsed the cycle after a read is accepted
        set_in(1'b0, 12'h0, 16'h0, 1'b0, 12'h0, 16'h0, 1'b1, 12'h805);
        eval_cycle("rd_before_rst");
        next_cycle();
        rst_n = 1'b0;
        set_in(1'b1, 12'h001, 16'h5555, 1'b0, 12'h0, 16'h0, 1'b0, 12'h0);
        #2;
        chk("rst_pulse_quiet", 160'({bus.wr1_ready, bus.mem_men, bus.rd_data_valid}), 160'(0));
        next_cycle();
        rst_n = 1'b1;
        rdq.delete();
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("sweep_restart", {14'b0, bus.rd_data_valid, bus.wr1_ready, bus.wr2_ready, bus.rd_ready,
                                  bus.mem_men, bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_bm, bus.mem_din},
                                 {14'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 11'(i), {64{1'b1}}, 64'h0});
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/weight_mem_sched.md
Name: weight_mem_sched

Overview:
- Cycle-level scheduler that shares one single-port 2048x64 weight SRAM macro between two 16-bit write loaders and one 32-bit read client (neuron core).
- Replaces fixed combinational priority with valid/ready handshakes, starvation-bounded arbitration, round-robin between writers, a tracked 2-cycle read pipeline and a post-reset clear sweep.
- Sits between the weight loaders / neuron core and the SRAM macro pins (MEN/WEN/REN/ADDR/DIN/BM/DOUT).

Parameters:
- DEPTH, 2048, number of 64-bit macro rows.
- ROW_W, 11, row address width (clog2(DEPTH)).
- STARVE_MAX, 4, consecutive cycles a pending write may lose to reads before it is forced through.
- CLEAR_ON_RESET, 1, 1 = zero every row after reset before serving requests; 0 = go straight to RUN.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr1_valid  in  1  loader 1 write request.
- wr1_ready  out  1  loader 1 write accepted this cycle.
- wr1_addr  in  12  loader 1 halfword address; bit 11 selects lane, bits 10:0 select row.
- wr1_data  in  16  loader 1 halfword.
- wr2_valid / wr2_ready / wr2_addr / wr2_data  in/out/in/in  1/1/12/16  loader 2, same semantics.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted this cycle.
- rd_addr  in  12  word address; bit 11 selects 32-bit half, bits 10:0 select row.
- rd_data_valid  out  1  rd_data valid this cycle, no backpressure.
- rd_data  out  32  read word.
- init_done  out  1  high once the clear sweep has finished; stays high until reset.
- mem_men, mem_wen, mem_ren  out  1 each  macro enable, write enable, read enable.
- mem_addr  out  11  macro row address.
- mem_din  out  64  macro write data.
- mem_bm  out  64  macro bit mask.
- mem_dout  in  64  macro read data, valid the cycle after mem_ren.

Behaviour:
- Transfer rule: a transfer occurs when valid && ready; ready depends combinationally on the valid inputs and internal state. At most one ready is high per cycle, except under the optional merge feature.
- Macro pins are combinational from the granted request in the same cycle. mem_men = mem_wen | mem_ren. When idle, all macro outputs are 0.
- Write lane mapping (mem_din is 0 outside the masked lane):
  - wr1, addr[11]=1: bm = FFFF000000000000, data in [63:48].
  - wr1, addr[11]=0: bm = 00000000FFFF0000, data in [31:16].
  - wr2, addr[11]=1: bm = 0000FFFF00000000, data in [47:32].
  - wr2, addr[11]=0: bm = 000000000000FFFF, data in [15:0].
- FSM state CLEAR (entered on reset if CLEAR_ON_RESET=1):
  - All readies are 0.
  - A row counter runs 0..DEPTH-1, one row per cycle, with mem_wen=1, bm all ones, din=0.
  - After row DEPTH-1 the FSM moves to RUN; init_done=1 from the next cycle. The sweep takes exactly DEPTH cycles.
- FSM state RUN: init_done=1. Arbitration, in priority order:
  1. If any write is pending and starve_cnt==STARVE_MAX: grant a write.
  2. Else if rd_valid: grant the read.
  3. Else: grant a write.
- Writer choice: if only one writer is valid, grant it. If both are valid, grant the writer indicated by the round-robin pointer. The pointer points to wr1 after reset and moves to the other writer after every write grant.
- starve_cnt:
  - Increments in each cycle where a write is valid and the read wins, saturating at STARVE_MAX.
  - Clears on any write grant, and in any cycle with no valid write.
- Read pipeline, read accepted in cycle T:
  - mem_ren=1 in T; addr[11] is captured.
  - In T+1, mem_dout is half-selected (1 = [63:32], 0 = [31:0]) and registered.
  - rd_data_valid=1 with rd_data in T+2. Back-to-back reads sustain one word per cycle.
- A write to the same row in the cycle after a read does not corrupt the in-flight read; the macro has already latched it.
- Reset values: every ready=0, rd_data_valid=0, rd_data=0, init_done=0 (or 1 when CLEAR_ON_RESET=0), all mem_* outputs 0, starve_cnt=0, pointer=wr1.
- Reset asserted mid-operation: in-flight read valid bits are dropped (no rd_data_valid pulse). The clear sweep restarts from row 0.

Optional Feature:
- Macro WMEM_WR_MERGE_EN.
- Defined: when both writers are valid, target the same row (addr[10:0] equal) and a write is being granted, both readies go high in the same cycle. A single macro write is issued with bm = OR of both lane masks and din = OR of both lane data. This counts as one write grant; the round-robin pointer is unchanged.
- Undefined: writers are strictly serialized.

Decomposition:
- Package weight_mem_pkg holds:
  - FSM state enum {CLEAR, RUN}.
  - The four 64-bit lane-mask constants.
  - Lane-placement function (port, addr[11], data) -> {bm, din}.
- Sub-module weight_mem_rd_pipe: 2-stage read valid/half-select pipeline with rd_data register.

Test Plan:
- Reset with CLEAR_ON_RESET=1, requests pending -> exactly 2048 cycles of mem_wen with bm=all ones, din=0, rows 0..2047; readies stay 0; init_done rises the next cycle.
- wr1 addr=0x805 data=0xABCD, then rd addr=0x805 -> mem_bm=FFFF000000000000 on row 5; rd_data=0xABCD0000 two cycles after rd acceptance.
- wr1 and wr2 continuously valid, no reads -> grants alternate wr1, wr2, wr1, ... starting with wr1.
- rd_valid held high with wr1 valid, STARVE_MAX=4 -> 4 read grants, then one wr1 grant, then reads resume.
- Reset pulsed one cycle after a read is accepted -> no rd_data_valid pulse; sweep restarts at row 0.
- WMEM_WR_MERGE_EN defined; wr1 addr=0x003 and wr2 addr=0x003 valid together -> both readies high; one write with bm=00000000FFFFFFFF and both halfwords placed.
